// File: rtl/byte_demux_loader.sv
// Byte stream to 32-lane register file loader with auto-incrementing write pointer.
// Optional even-parity check on incoming bytes when BYTE_DEMUX_PARITY_EN is defined.
module byte_demux_loader #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 32,
   localparam int unsigned PW = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
`ifdef BYTE_DEMUX_PARITY_EN
   input  logic                     in_parity,
   output logic                     par_err,
`endif
   input  logic [PW-1:0]            select,
   input  logic                     load_sel,
   input  logic                     clear,
   output logic [PW-1:0]            wr_ptr,
   output logic [WIDTH*DEPTH-1:0]   lanes,
   output logic [DEPTH-1:0]         lane_valid,
   output logic                     full,
   output logic                     frame_done
);

   logic [WIDTH-1:0] r_lanes [DEPTH];
   logic [DEPTH-1:0] r_lane_valid;
   logic [PW-1:0]    r_wr_ptr;
   logic             r_full;
   logic             r_frame_done;

   logic [WIDTH-1:0] w_lanes_nxt [DEPTH];
   logic [DEPTH-1:0] w_lane_valid_nxt;
   logic [PW-1:0]    w_wr_ptr_nxt;
   logic             w_full_nxt;
   logic             w_frame_done_nxt;
   logic             w_accept;
   logic             w_store;
   logic             w_at_last;

   assign in_ready  = !r_full && !load_sel && !clear;
   assign w_accept  = in_valid && in_ready;
   assign w_at_last = (r_wr_ptr == PW'(DEPTH - 1));

`ifdef BYTE_DEMUX_PARITY_EN
   logic w_par_bad;
   logic r_par_err;

   // A bad-parity byte still completes its handshake; it is just not stored.
   assign w_par_bad = ^{in_data, in_parity};
   assign w_store   = w_accept && !w_par_bad;
   assign par_err   = r_par_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_par_err <= 1'b0;
      end else begin
         r_par_err <= w_accept && w_par_bad;
      end
   end
`else
   assign w_store = w_accept;
`endif

   always_comb begin
      w_lanes_nxt      = r_lanes;
      w_lane_valid_nxt = r_lane_valid;
      w_wr_ptr_nxt     = r_wr_ptr;
      w_full_nxt       = r_full;
      w_frame_done_nxt = 1'b0;
      if (clear) begin
         w_wr_ptr_nxt     = '0;
         w_full_nxt       = 1'b0;
         w_lane_valid_nxt = '0;
      end else if (load_sel) begin
         w_wr_ptr_nxt = select;
      end else if (w_store) begin
         w_lanes_nxt[r_wr_ptr]      = in_data;
         w_lane_valid_nxt[r_wr_ptr] = 1'b1;
         w_wr_ptr_nxt               = r_wr_ptr + PW'(1);
         if (w_at_last) begin
            w_full_nxt       = 1'b1;
            w_frame_done_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            r_lanes[k] <= '0;
         end
         r_lane_valid <= '0;
         r_wr_ptr     <= '0;
         r_full       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_lanes      <= w_lanes_nxt;
         r_lane_valid <= w_lane_valid_nxt;
         r_wr_ptr     <= w_wr_ptr_nxt;
         r_full       <= w_full_nxt;
         r_frame_done <= w_frame_done_nxt;
      end
   end

   for (genvar k = 0; k < int'(DEPTH); k++) begin : g_flat
      assign lanes[k*WIDTH +: WIDTH] = r_lanes[k];
   end

   assign lane_valid = r_lane_valid;
   assign wr_ptr     = r_wr_ptr;
   assign full       = r_full;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_byte_demux_loader.sv
// Directed-vector bench for byte_demux_loader; parity tests run when
// BYTE_DEMUX_PARITY_EN is defined.
module tb_byte_demux_loader;

   logic         clk = 1'b0;
   logic         reset;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_ready;
   logic [4:0]   select;
   logic         load_sel;
   logic         clear;
   logic [4:0]   wr_ptr;
   logic [255:0] lanes;
   logic [31:0]  lane_valid;
   logic         full;
   logic         frame_done;
`ifdef BYTE_DEMUX_PARITY_EN
   logic         in_parity;
   logic         par_err;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   byte_demux_loader dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
`ifdef BYTE_DEMUX_PARITY_EN
      .in_parity  (in_parity),
      .par_err    (par_err),
`endif
      .select     (select),
      .load_sel   (load_sel),
      .clear      (clear),
      .wr_ptr     (wr_ptr),
      .lanes      (lanes),
      .lane_valid (lane_valid),
      .full       (full),
      .frame_done (frame_done)
   );

   function automatic logic [7:0] lane_of(input int k);
      return lanes[k*8 +: 8];
   endfunction

   // Advance one clock; outputs are then sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; load_sel = 1'b0; clear = 1'b0;
      in_data = 8'h00; select = 5'd0;
`ifdef BYTE_DEMUX_PARITY_EN
      in_parity = 1'b0;
`endif
      step(); step();
      reset = 1'b0;
      #1;
      n_vec++;
      if (lanes !== 256'd0) begin
         n_err++; $display("FAIL reset_lanes got %h want 0", lanes);
      end
      n_vec++;
      if (lane_valid !== 32'd0) begin
         n_err++; $display("FAIL reset_lane_valid got %h want 0", lane_valid);
      end
      n_vec++;
      if ({wr_ptr, full, frame_done, in_ready} !== {5'd0, 1'b0, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL reset_ctrl got ptr=%0d full=%b fd=%b rdy=%b want 0 0 0 1",
                  wr_ptr, full, frame_done, in_ready);
      end
   endtask

   task automatic test_stream();
      for (int k = 0; k < 32; k++) begin
         in_data = 8'(k); in_valid = 1'b1;
         n_vec++;
         if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL stream_ready k=%0d got %b want 1", k, in_ready);
         end
         step();
         n_vec++;
         if (lane_of(k) !== 8'(k)) begin
            n_err++; $display("FAIL stream_lane k=%0d got %h want %h", k, lane_of(k), 8'(k));
         end
         n_vec++;
         if (frame_done !== (k == 31)) begin
            n_err++; $display("FAIL stream_frame_done k=%0d got %b want %b", k, frame_done, k == 31);
         end
      end
      n_vec++;
      if ({full, wr_ptr, in_ready} !== {1'b1, 5'd0, 1'b0}) begin
         n_err++;
         $display("FAIL stream_full got full=%b ptr=%0d rdy=%b want 1 0 0", full, wr_ptr, in_ready);
      end
      in_data = 8'hAA;
      step();
      in_valid = 1'b0;
      n_vec++;
      if (lane_of(0) !== 8'h00 || frame_done !== 1'b0 || full !== 1'b1 || wr_ptr !== 5'd0) begin
         n_err++;
         $display("FAIL stream_blocked got lane0=%h fd=%b full=%b ptr=%0d want 00 0 1 0",
                  lane_of(0), frame_done, full, wr_ptr);
      end
      n_vec++;
      if (lane_valid !== 32'hFFFF_FFFF) begin
         n_err++; $display("FAIL stream_lane_valid got %h want ffffffff", lane_valid);
      end
   endtask

   task automatic test_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
      n_vec++;
      if ({full, lane_valid, wr_ptr} !== {1'b0, 32'd0, 5'd0}) begin
         n_err++;
         $display("FAIL clear_state got full=%b lv=%h ptr=%0d want 0 0 0", full, lane_valid, wr_ptr);
      end
      n_vec++;
      if (lane_of(5) !== 8'h05 || lane_of(31) !== 8'h1F) begin
         n_err++;
         $display("FAIL clear_retain got l5=%h l31=%h want 05 1f", lane_of(5), lane_of(31));
      end
      in_data = 8'h55; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n_vec++;
      if (lane_of(0) !== 8'h55 || lane_of(1) !== 8'h01 || lane_valid !== 32'h1) begin
         n_err++;
         $display("FAIL clear_next got l0=%h l1=%h lv=%h want 55 01 1",
                  lane_of(0), lane_of(1), lane_valid);
      end
   endtask

   task automatic test_load_sel();
      clear = 1'b1;
      step();
      clear = 1'b0;
      in_data = 8'h11; in_valid = 1'b1; load_sel = 1'b1; select = 5'd30;
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_err++; $display("FAIL load_ready got %b want 0", in_ready);
      end
      step();
      load_sel = 1'b0;
      n_vec++;
      if (wr_ptr !== 5'd30 || lane_of(30) !== 8'h1E || lane_valid !== 32'd0) begin
         n_err++;
         $display("FAIL load_noaccept got ptr=%0d l30=%h lv=%h want 30 1e 0",
                  wr_ptr, lane_of(30), lane_valid);
      end
      in_data = 8'h22;
      step();
      in_data = 8'h33;
      step();
      in_valid = 1'b0;
      n_vec++;
      if (lane_of(30) !== 8'h22 || lane_of(31) !== 8'h33) begin
         n_err++;
         $display("FAIL load_lanes got l30=%h l31=%h want 22 33", lane_of(30), lane_of(31));
      end
      n_vec++;
      if (full !== 1'b1 || frame_done !== 1'b1 || lane_valid !== 32'hC000_0000) begin
         n_err++;
         $display("FAIL load_full got full=%b fd=%b lv=%h want 1 1 c0000000",
                  full, frame_done, lane_valid);
      end
      step();
      n_vec++;
      if (frame_done !== 1'b0) begin
         n_err++; $display("FAIL load_fd_pulse got %b want 0", frame_done);
      end
   endtask

   task automatic test_gapped();
      clear = 1'b1;
      step();
      clear = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_data = 8'h80 + 8'(i); in_valid = 1'b1;
         step();
         in_valid = 1'b0; in_data = 8'hEE;
         step();
      end
      for (int i = 0; i < 8; i++) begin
         n_vec++;
         if (lane_of(i) !== 8'h80 + 8'(i)) begin
            n_err++;
            $display("FAIL gapped_lane i=%0d got %h want %h", i, lane_of(i), 8'h80 + 8'(i));
         end
      end
      n_vec++;
      if (wr_ptr !== 5'd8 || lane_valid !== 32'h0000_00FF) begin
         n_err++;
         $display("FAIL gapped_ptr got ptr=%0d lv=%h want 8 ff", wr_ptr, lane_valid);
      end
   endtask

   task automatic test_reset_mid();
      clear = 1'b1;
      step();
      clear = 1'b0;
      for (int i = 0; i < 10; i++) begin
         in_data = 8'h40 + 8'(i); in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      n_vec++;
      if (wr_ptr !== 5'd10) begin
         n_err++; $display("FAIL midreset_pre got ptr=%0d want 10", wr_ptr);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      n_vec++;
      if (lanes !== 256'd0 || lane_valid !== 32'd0) begin
         n_err++; $display("FAIL midreset_data got lanes=%h lv=%h want 0 0", lanes, lane_valid);
      end
      n_vec++;
      if ({wr_ptr, full, in_ready} !== {5'd0, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL midreset_ctrl got ptr=%0d full=%b rdy=%b want 0 0 1", wr_ptr, full, in_ready);
      end
   endtask

`ifdef BYTE_DEMUX_PARITY_EN
   task automatic test_parity();
      in_data = 8'h03; in_parity = 1'b1; in_valid = 1'b1;
      step();
      n_vec++;
      if (par_err !== 1'b1 || lane_of(0) !== 8'h00 || wr_ptr !== 5'd0 || lane_valid !== 32'd0) begin
         n_err++;
         $display("FAIL parity_bad got perr=%b l0=%h ptr=%0d lv=%h want 1 00 0 0",
                  par_err, lane_of(0), wr_ptr, lane_valid);
      end
      in_parity = 1'b0;
      step();
      in_valid = 1'b0;
      n_vec++;
      if (par_err !== 1'b0 || lane_of(0) !== 8'h03 || wr_ptr !== 5'd1) begin
         n_err++;
         $display("FAIL parity_good got perr=%b l0=%h ptr=%0d want 0 03 1",
                  par_err, lane_of(0), wr_ptr);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_clear();
      test_load_sel();
      test_gapped();
      test_reset_mid();
`ifdef BYTE_DEMUX_PARITY_EN
      test_parity();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
